// File: rtl/qmult_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qmult_rr_sched: round-robin arbiter in front of one shared Q-format        |
// | multiplier; returns tagged, optionally saturated products.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module qmult_rr_sched #(
  parameter int N       = 16,
  parameter int Q       = 12,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1,
  parameter bit SAT     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*N-1:0]         req_a,
  input  logic [NREQ*N-1:0]         req_b,
  output logic [N-1:0]              mul_a,
  output logic [N-1:0]              mul_b,
  input  logic [N-1:0]              mul_q,
  input  logic                      mul_ovf,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [N-1:0]              rsp_q,
  output logic                      rsp_ovf,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int LCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [LCW-1:0] LAT_LAST = LCW'(MUL_LAT - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  if (NREQ < 2 || MUL_LAT < 1 || Q >= N) begin : g_bad_params
    $error("qmult_rr_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LCW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [N-1:0]     mul_a_q, mul_a_d;
  logic [N-1:0]     mul_b_q, mul_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [N-1:0]     rsp_q_q, rsp_q_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic             prod_neg;
  logic [N-1:0]     sat_val;

  // Scan from the highest offset down so the lane closest to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign prod_neg = mul_a_q[N-1] ^ mul_b_q[N-1];
  assign sat_val  = prod_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lat_cnt_d   = lat_cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_q_d     = rsp_q_q;
    rsp_ovf_d   = rsp_ovf_q;
    unique case (state_q)
      // In IDLE the granted lane is always ready, so grant_vld is the handshake.
      S_IDLE: begin
        if (grant_vld) begin
          mul_a_d   = req_a[int'(grant_idx)*N +: N];
          mul_b_d   = req_b[int'(grant_idx)*N +: N];
          rsp_id_d  = grant_idx;
          lat_cnt_d = '0;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LAT_LAST) begin
          rsp_q_d     = (SAT && mul_ovf) ? sat_val : mul_q;
          rsp_ovf_d   = mul_ovf;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (rsp_id_q == LAST_ID) ? '0 : rsp_id_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      lat_cnt_q   <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_cnt_q   <= lat_cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_q_q     <= rsp_q_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_qmult_rr_sched.sv
`default_nettype none
// Bench for qmult_rr_sched: two instances (MUL_LAT=1 and MUL_LAT=3) share
// stimulus and are each scored against a transaction-level model.
module tb_qmult_rr_sched;

  localparam int N    = 16;
  localparam int Q    = 12;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_ready;

  logic [NREQ-1:0] ready [2];
  logic [N-1:0]    mul_a [2];
  logic [N-1:0]    mul_b [2];
  logic [N-1:0]    mul_q [2];
  logic            mul_ovf [2];
  logic            rsp_valid [2];
  logic [IDW-1:0]  rsp_id [2];
  logic [N-1:0]    rsp_q [2];
  logic            rsp_ovf [2];
  logic            busy [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Raw multiplier: floor-shifted product truncated to N bits, flag on range loss.
  function automatic logic [N:0] mul_model(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
    p = (longint'($signed(a)) * longint'($signed(b))) >>> Q;
    return {(p > MAXV || p < MINV), 16'(p)};
  endfunction

  // Response the scheduler should return for an operand pair (saturating).
  function automatic logic [N:0] exp_rsp(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
    p = (longint'($signed(a)) * longint'($signed(b))) >>> Q;
    if (p > MAXV) return {1'b1, 16'h7FFF};
    if (p < MINV) return {1'b1, 16'h8000};
    return {1'b0, 16'(p)};
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    case ($urandom % 4)
      0: v = '0;
      1: v = 16'($urandom);
      default: begin
        v = 16'($urandom_range(0, 16'h3FFF));
        if ($urandom % 2 == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  assign {mul_ovf[0], mul_q[0]} = mul_model(mul_a[0], mul_b[0]);

  logic [N:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= mul_model(mul_a[1], mul_b[1]);
    pipe2 <= pipe1;
  end
  assign {mul_ovf[1], mul_q[1]} = pipe2;

  qmult_rr_sched #(.N(N), .Q(Q), .NREQ(NREQ), .MUL_LAT(1), .SAT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[0]),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_q(mul_q[0]), .mul_ovf(mul_ovf[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id[0]), .rsp_q(rsp_q[0]),
    .rsp_ovf(rsp_ovf[0]), .busy(busy[0])
  );

  qmult_rr_sched #(.N(N), .Q(Q), .NREQ(NREQ), .MUL_LAT(3), .SAT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[1]),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_q(mul_q[1]), .mul_ovf(mul_ovf[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id[1]), .rsp_q(rsp_q[1]),
    .rsp_ovf(rsp_ovf[1]), .busy(busy[1])
  );

  // Transaction model state, one slot per instance.
  bit         m_busy [2];
  int         m_ptr [2];
  int         m_acc [2];
  int         e_id [2];
  logic [N-1:0] e_q [2];
  logic       e_ovf [2];
  int         first_v [2];
  logic [N-1:0] last_q [2];
  logic       last_ovf [2];
  int         last_id [2];
  int         glog0 [$];
  int         glog1 [$];
  int         g;
  logic [NREQ-1:0] exp_rdy;
  logic       exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 1'b0;
        m_ptr[d]  = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!m_busy[d]) begin
          g = -1;
          for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(m_ptr[d] + k) % NREQ]) g = (m_ptr[d] + k) % NREQ;
          exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
          check($sformatf("req_ready dut%0d", d), 32'(ready[d]), 32'(exp_rdy));
          check($sformatf("busy_idle dut%0d", d), 32'(busy[d]), 32'd0);
          check($sformatf("rsp_valid_idle dut%0d", d), 32'(rsp_valid[d]), 32'd0);
          if (g >= 0) begin
            {e_ovf[d], e_q[d]} = exp_rsp(req_a[g*N +: N], req_b[g*N +: N]);
            e_id[d]    = g;
            m_acc[d]   = cyc;
            m_busy[d]  = 1'b1;
            first_v[d] = -1;
            if (d == 0) glog0.push_back(g);
            else        glog1.push_back(g);
          end
        end else begin
          exp_v = (cyc >= m_acc[d] + lat_of(d) + 1);
          check($sformatf("req_ready_busy dut%0d", d), 32'(ready[d]), 32'd0);
          check($sformatf("busy dut%0d", d), 32'(busy[d]), 32'd1);
          check($sformatf("rsp_valid dut%0d", d), 32'(rsp_valid[d]), 32'(exp_v));
          if (exp_v && rsp_valid[d]) begin
            if (first_v[d] < 0) first_v[d] = cyc - m_acc[d];
            check($sformatf("rsp_id dut%0d", d), 32'(rsp_id[d]), 32'(e_id[d]));
            check($sformatf("rsp_q dut%0d", d), 32'(rsp_q[d]), 32'(e_q[d]));
            check($sformatf("rsp_ovf dut%0d", d), 32'(rsp_ovf[d]), 32'(e_ovf[d]));
            if (rsp_ready) begin
              m_busy[d]   = 1'b0;
              m_ptr[d]    = (e_id[d] + 1) % NREQ;
              last_q[d]   = rsp_q[d];
              last_ovf[d] = rsp_ovf[d];
              last_id[d]  = int'(rsp_id[d]);
            end
          end
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s rsp_valid dut%0d", tag, d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("%s busy dut%0d", tag, d), 32'(busy[d]), 32'd0);
      check($sformatf("%s mul_a dut%0d", tag, d), 32'(mul_a[d]), 32'd0);
      check($sformatf("%s mul_b dut%0d", tag, d), 32'(mul_b[d]), 32'd0);
      check($sformatf("%s rsp_id dut%0d", tag, d), 32'(rsp_id[d]), 32'd0);
      check($sformatf("%s rsp_q dut%0d", tag, d), 32'(rsp_q[d]), 32'd0);
      check($sformatf("%s rsp_ovf dut%0d", tag, d), 32'(rsp_ovf[d]), 32'd0);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy[0] || busy[1]) && t < 80) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(t < 80), 32'd1);
  endtask

  task automatic wait_accept(input int lane);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready[0][lane] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 32'(ready[0][lane]), 32'd1);
  endtask

  // One isolated operation on both instances, then explicit result checks.
  task automatic do_op(input string tag, input int lane, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] eq, input logic eo);
    @(posedge clk); #1;
    req_a[lane*N +: N] = a;
    req_b[lane*N +: N] = b;
    req_valid = NREQ'(1 << lane);
    wait_accept(lane);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s latency dut%0d", tag, d), 32'(first_v[d]), 32'(lat_of(d) + 1));
      check($sformatf("%s q dut%0d", tag, d), 32'(last_q[d]), 32'(eq));
      check($sformatf("%s ovf dut%0d", tag, d), 32'(last_ovf[d]), 32'(eo));
      check($sformatf("%s id dut%0d", tag, d), 32'(last_id[d]), 32'(lane));
    end
  endtask

  initial begin
    int n0, n1, t;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;

    // Basic, sign and saturation cases
    do_op("t1", 2, 16'h1800, 16'h2000, 16'h3000, 1'b0);
    do_op("t2a", 0, 16'hE800, 16'h2000, 16'hD000, 1'b0);
    do_op("t2b", 0, 16'hE800, 16'hE800, 16'h2400, 1'b0);
    do_op("t3a", 0, 16'h7000, 16'h2000, 16'h7FFF, 1'b1);
    do_op("t3b", 0, 16'h9000, 16'h2000, 16'h8000, 1'b1);
    do_op("t3c", 1, 16'h7000, 16'hE000, 16'h8000, 1'b1);
    do_op("t3d", 3, 16'h9000, 16'hE000, 16'h7FFF, 1'b1);
    do_op("t3z", 1, 16'h0000, 16'h7FFF, 16'h0000, 1'b0);

    // Round robin from reset with all lanes requesting
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = glog0.size();
    n1 = glog1.size();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = rand_op();
      req_b[i*N +: N] = rand_op();
    end
    req_valid = '1;
    t = 0;
    while (glog1.size() < n1 + 6 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    req_valid = '0;
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr order dut0 #%0d", i),
            32'((n0 + i < glog0.size()) ? glog0[n0 + i] : -1), 32'(i % NREQ));
      check($sformatf("rr order dut1 #%0d", i),
            32'((n1 + i < glog1.size()) ? glog1[n1 + i] : -1), 32'(i % NREQ));
    end

    // Backpressure held in RESP while other lanes keep requesting
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_a[1*N +: N] = 16'h1000;
    req_b[1*N +: N] = 16'h3000;
    req_valid = 4'b0010;
    wait_accept(1);
    @(posedge clk); #1;
    req_valid = 4'b1101;
    repeat (14) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("bp rsp_valid dut%0d", d), 32'(rsp_valid[d]), 32'd1);
      check($sformatf("bp rsp_q dut%0d", d), 32'(rsp_q[d]), 32'h3000);
      check($sformatf("bp busy dut%0d", d), 32'(busy[d]), 32'd1);
      check($sformatf("bp ready dut%0d", d), 32'(ready[d]), 32'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("bp release busy dut%0d", d), 32'(busy[d]), 32'd0);

    // Reset in the middle of an operation
    do_op("pre_rst", 2, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    @(posedge clk); #1;
    req_a[3*N +: N] = 16'h2000;
    req_b[3*N +: N] = 16'h2000;
    req_valid = 4'b1000;
    wait_accept(3);
    @(posedge clk); #1;
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midop");
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = '1;
    @(negedge clk);
    check("post_rst grant dut0", 32'(ready[0]), 32'h1);
    check("post_rst grant dut1", 32'(ready[1]), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*N +: N] = rand_op();
        req_b[i*N +: N] = rand_op();
      end
      rsp_ready = ($urandom % 4 != 0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
